// File: rtl/mode_selector.sv
// rtl/mode_selector.sv - two-key wrapping mode stepper with release-triggered step.
// Optional per-key debouncer enabled by MODE_SELECTOR_DEBOUNCE_EN.
module mode_selector #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int MODE_W         = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next_key,
    input  logic              prev_key,
    output logic [MODE_W-1:0] mode,
    output logic              mode_change,
    output logic              key_busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARM_NEXT = 2'd1;
    localparam logic [1:0] ARM_PREV = 2'd2;
    localparam logic [1:0] LOCKOUT  = 2'd3;

    localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

    // Bit 0 carries next_key, bit 1 carries prev_key throughout.
    logic [1:0] sync_1;
    logic [1:0] sync_2;
    logic [1:0] key_db;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 2'b00;
            sync_2 <= 2'b00;
        end else begin
            sync_1 <= {prev_key, next_key};
            sync_2 <= sync_1;
        end
    end

`ifdef MODE_SELECTOR_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] db_cnt [2];

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_db    <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync_2[k] == key_db[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == CNT_LAST) begin
                    key_db[k] <= sync_2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 16'd1;
                end
            end
        end
    end
`else
    assign key_db = sync_2;
`endif

    logic       next_db;
    logic       prev_db;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       step_up;
    logic       step_dn;

    assign next_db = key_db[0];
    assign prev_db = key_db[1];

    always_comb begin
        state_nxt = state;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        case (state)
            IDLE: begin
                if (next_db && prev_db)  state_nxt = LOCKOUT;
                else if (next_db)        state_nxt = ARM_NEXT;
                else if (prev_db)        state_nxt = ARM_PREV;
            end
            ARM_NEXT: begin
                if (prev_db) begin
                    state_nxt = LOCKOUT;
                end else if (!next_db) begin
                    state_nxt = IDLE;
                    step_up   = 1'b1;
                end
            end
            ARM_PREV: begin
                if (next_db) begin
                    state_nxt = LOCKOUT;
                end else if (!prev_db) begin
                    state_nxt = IDLE;
                    step_dn   = 1'b1;
                end
            end
            LOCKOUT: begin
                if (!next_db && !prev_db) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode        <= '0;
            mode_change <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode_change <= step_up | step_dn;
            if (step_up) begin
                mode <= (mode >= MODE_MAX) ? '0 : mode + 1'b1;
            end else if (step_dn) begin
                mode <= (mode == '0 || mode > MODE_MAX) ? MODE_MAX : mode - 1'b1;
            end
        end
    end

    assign key_busy = (state != IDLE);

endmodule

// File: doc/mode_selector.md
MODE_SELECTOR -- requirements
Module: mode_selector

Interface
REQ-001 Parameter NUM_MODES, default 4: number of selectable modes, legal range 2..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: stable-sample count to accept a key level change, legal range 1..65535.
REQ-003 Derived width MODE_W = max(1, clog2(NUM_MODES)); not user-settable.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 next_key  input  1  raw asynchronous "advance mode" button, high = pressed.
REQ-007 prev_key  input  1  raw asynchronous "step back mode" button, high = pressed.
REQ-008 mode  output  MODE_W  current mode index, always in 0..NUM_MODES-1.
REQ-009 mode_change  output  1  single-cycle pulse, high in the first cycle mode shows its new value.
REQ-010 key_busy  output  1  high whenever the FSM is in any state other than IDLE.

Function
REQ-011 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Debouncer per key: debounced level SHALL flip only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-013 FSM states SHALL be IDLE, ARM_NEXT, ARM_PREV, LOCKOUT.
REQ-014 IDLE: next_db=1, prev_db=0 -> ARM_NEXT; prev_db=1, next_db=0 -> ARM_PREV; both 1 -> LOCKOUT; else stay.
REQ-015 ARM_NEXT: next_db falls with prev_db=0 -> IDLE and mode steps up by one; prev_db rises -> LOCKOUT, no mode step.
REQ-016 ARM_PREV: mirror of REQ-015 with keys swapped; mode steps down by one.
REQ-017 LOCKOUT: stay until both debounced keys are 0, then IDLE; mode SHALL NOT change.
REQ-018 Mode SHALL step only on release, at most once per press; a held key never repeats.
REQ-019 Wrap-around: NUM_MODES-1 stepped up -> 0; 0 stepped down -> NUM_MODES-1; mode never holds a value >= NUM_MODES.
REQ-020 mode and mode_change SHALL be registered; mode updates on the clock edge leaving ARM_* for IDLE, with mode_change high for exactly that following cycle.
REQ-021 Latency raw release -> mode update SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles with the debouncer compiled in, 3 cycles without.
REQ-022 Unreachable state encodings SHALL return to IDLE on the next clock, mode unchanged.

Reset
REQ-023 While rst=1: mode=0, mode_change=0, key_busy=0, FSM=IDLE, synchronizers, debounced levels and counters all 0.
REQ-024 After rst deasserts with a key already held, that key SHALL be treated as a new press (debounced, then ARM_*), not discarded.
REQ-025 rst asserted mid-press (ARM_* or LOCKOUT) SHALL abort the press with no mode step and no mode_change pulse.

Configuration
REQ-026 Macro MODE_SELECTOR_DEBOUNCE_EN defined: debouncers per REQ-012 are built and DEBOUNCE_CYCLES applies.
REQ-027 Macro undefined: debounced level equals synchronized level, no counters are built, DEBOUNCE_CYCLES is ignored; all FSM behaviour otherwise identical.

Verification (NUM_MODES=5, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-028 Five clean next_key presses (hold 20 cycles, release 20) from reset -> mode 1,2,3,4,0; exactly five mode_change pulses, each 1 cycle.
REQ-029 One prev_key press from reset -> mode 4; pulse arrives 7 cycles after raw release.
REQ-030 next_key glitches of 3-cycle width repeated 10 times -> mode stays 0, key_busy stays 0, no pulse.
REQ-031 Press next_key, press prev_key while held, release both in either order -> LOCKOUT entered, mode unchanged, key_busy returns 0 after both released.
REQ-032 Hold next_key 1000 cycles then release -> single step 0->1, no repeat while held.
REQ-033 Macro undefined: 1-cycle next_key pulse -> mode 0->1, mode_change 3 cycles after the raw falling edge; rst pulse during a held key -> mode 0, no pulse.
